snn_batch_control: RTL

SNN_BATCH_CONTROL -- requirements
Module: snn_batch_control

---
 rtl/snn_batch_control_if.sv | 43 ++++
 rtl/snn_batch_control.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/snn_batch_control_if.sv
// Handshake bundle between the batch sequencer and the SNN stage datapath.
// The host/datapath side uses master; the sequencer uses slave.
interface snn_batch_control_if #(
    parameter int unsigned NIMG_W = 10
);
    logic              start_main;
    logic [1:0]        train_test_classify;
    logic [NIMG_W-1:0] num_images;
    logic              abort;
    logic              err_clr;
    logic              valid_buffering;
    logic              valid_rfing;
    logic              valid_maxing;
    logic              done_core_img;
    logic              valid_deciding;

    logic              buffering;
    logic              rfing;
    logic              maxing;
    logic              coring;
    logic              deciding;
    logic              start_core_img;
    logic              valid_img;
    logic              valid_all;
    logic [NIMG_W-1:0] img_idx;
    logic              busy;
    logic              err;
    logic [2:0]        err_stage;

    modport master (
        output start_main, train_test_classify, num_images, abort, err_clr,
        output valid_buffering, valid_rfing, valid_maxing, done_core_img, valid_deciding,
        input  buffering, rfing, maxing, coring, deciding,
        input  start_core_img, valid_img, valid_all, img_idx, busy, err, err_stage
    );

    modport slave (
        input  start_main, train_test_classify, num_images, abort, err_clr,
        input  valid_buffering, valid_rfing, valid_maxing, done_core_img, valid_deciding,
        output buffering, rfing, maxing, coring, deciding,
        output start_core_img, valid_img, valid_all, img_idx, busy, err, err_stage
    );
endinterface

// File: rtl/snn_batch_control.sv
// Batch sequencer for SNN image processing: walks each image through
// BUFF -> RF -> (MAX) -> CORE -> DECIDE with a per-stage timeout watchdog.
module snn_batch_control #(
    parameter int unsigned NIMG_W  = 10,
    parameter int unsigned TO_W    = 16,
    parameter int unsigned TIMEOUT = 50000
) (
    input logic                clk,
    input logic                rst,
    snn_batch_control_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle, StBuff, StRf, StMax, StCore, StDecide, StError
    } state_e;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [NIMG_W-1:0] count_q, count_d;
    logic [NIMG_W-1:0] idx_q, idx_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [2:0]        err_stage_q, err_stage_d;
    logic [2:0]        stage_code;
    logic              strobe;
    logic              timeout;
    logic              start_core_q, start_core_d;
    logic              valid_img_q, valid_img_d;
    logic              valid_all_q, valid_all_d;
    logic [4:0]        en_q, en_d;  // {buffering, rfing, maxing, coring, deciding}
    logic              busy_q, err_q;

    assign timeout = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        count_d      = count_q;
        idx_d        = idx_q;
        cnt_d        = '0;
        stage_code   = 3'd0;
        strobe       = 1'b0;
        start_core_d = 1'b0;
        valid_img_d  = 1'b0;
        valid_all_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start_main && (bus.train_test_classify != 2'b00) &&
                    (bus.num_images != '0)) begin
                    mode_d  = bus.train_test_classify;
                    count_d = bus.num_images;
                    idx_d   = '0;
                    state_d = StBuff;
                end
            end
            StBuff: begin
                stage_code = 3'd1;
                if (bus.valid_buffering) begin
                    strobe  = 1'b1;
                    state_d = StRf;
                end
            end
            StRf: begin
                stage_code = 3'd2;
                if (bus.valid_rfing) begin
                    strobe = 1'b1;
                    if (mode_q == 2'b01) begin
                        state_d = StMax;
                    end else begin
                        state_d      = StCore;
                        start_core_d = 1'b1;
                    end
                end
            end
            StMax: begin
                stage_code = 3'd3;
                if (bus.valid_maxing) begin
                    strobe       = 1'b1;
                    state_d      = StCore;
                    start_core_d = 1'b1;
                end
            end
            StCore: begin
                stage_code = 3'd4;
                if (bus.done_core_img) begin
                    strobe  = 1'b1;
                    state_d = StDecide;
                end
            end
            StDecide: begin
                stage_code = 3'd5;
                if (bus.valid_deciding) begin
                    strobe      = 1'b1;
                    valid_img_d = 1'b1;
                    if (idx_q == count_q - NIMG_W'(1)) begin
                        valid_all_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        idx_d   = idx_q + NIMG_W'(1);
                        state_d = StBuff;
                    end
                end
            end
            StError: begin
                if (bus.err_clr) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A completion strobe on the expiry cycle beats the watchdog.
        if ((stage_code != 3'd0) && !strobe) begin
            if (timeout) state_d = StError;
            else         cnt_d   = cnt_q + TO_W'(1);
        end

        if (bus.abort && (state_q != StIdle)) begin
            state_d      = StIdle;
            start_core_d = 1'b0;
            valid_img_d  = 1'b0;
            valid_all_d  = 1'b0;
            cnt_d        = '0;
        end

        if (state_d != StError)      err_stage_d = 3'd0;
        else if (state_q != StError) err_stage_d = stage_code;
        else                         err_stage_d = err_stage_q;

        en_d = 5'b00000;
        unique case (state_d)
            StBuff:   en_d = 5'b10000;
            StRf:     en_d = 5'b01000;
            StMax:    en_d = 5'b00100;
            StCore:   en_d = 5'b00010;
            StDecide: en_d = 5'b00001;
            default:  en_d = 5'b00000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            mode_q       <= 2'b00;
            count_q      <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            err_stage_q  <= 3'd0;
            start_core_q <= 1'b0;
            valid_img_q  <= 1'b0;
            valid_all_q  <= 1'b0;
            en_q         <= 5'b00000;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            err_stage_q  <= err_stage_d;
            start_core_q <= start_core_d;
            valid_img_q  <= valid_img_d;
            valid_all_q  <= valid_all_d;
            en_q         <= en_d;
            busy_q       <= (state_d != StIdle);
            err_q        <= (state_d == StError);
        end
    end

    assign bus.buffering      = en_q[4];
    assign bus.rfing          = en_q[3];
    assign bus.maxing         = en_q[2];
    assign bus.coring         = en_q[1];
    assign bus.deciding       = en_q[0];
    assign bus.start_core_img = start_core_q;
    assign bus.valid_img      = valid_img_q;
    assign bus.valid_all      = valid_all_q;
    assign bus.img_idx        = idx_q;
    assign bus.busy           = busy_q;
    assign bus.err            = err_q;
    assign bus.err_stage      = err_stage_q;
endmodule
